// File: rtl/uart_sample_tx_pkg.sv
// Shared definitions for the UART sample transmitter.
//   - tx_state_e       : byte-engine FSM states
//   - SYNC_BYTE        : realignment byte sent ahead of each sample when
//                        SYNC_BYTE_EN is defined
//   - bytes_per_sample : number of 8-bit frames needed for one sample
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int unsigned bytes_per_sample(input int unsigned sample_w);
        return sample_w / 32'd8;
    endfunction

endpackage

// File: rtl/uart_sample_tx_sample_fifo.sv
// Synchronous show-ahead FIFO used to buffer audio samples ahead of the
// byte engine.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (flushes the FIFO)
//   push, wdata   : write request and data (ignored while full)
//   pop, rdata    : read request; rdata always shows the oldest entry
//   full, empty   : occupancy flags
//   level         : current number of stored entries (0..DEPTH)
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == FULL_LEVEL);
    assign empty     = (level_r == '0);
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    // A full FIFO never takes a push, even when a pop happens in the same cycle.
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array write port; contents need no reset since level gates reads.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_sample_tx.sv
// Serialises audio samples onto the FTDI UART line as 8N1 frames, MSB byte
// of each sample first, with back-to-back frames sent without idle gaps.
// Optional feature macro: SYNC_BYTE_EN -- when defined, each sample is
// preceded by one frame carrying SYNC_BYTE (0xA5).
// Ports:
//   clk, rst      : int_clk from the PLL, synchronous active-high reset
//   sample_in     : sample data, accepted when sample_valid && sample_ready
//   sample_valid  : sample_in is valid
//   sample_ready  : a sample can be accepted this cycle
//   tx            : registered UART serial output, idles high
//   busy          : a frame is in progress or the FIFO holds samples
//   fifo_level    : current FIFO occupancy
module uart_sample_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 40,
    parameter int SAMPLE_W     = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_W-1:0]           sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned BYTES = bytes_per_sample(SAMPLE_W);
`ifdef SYNC_BYTE_EN
    localparam int unsigned FRAMES = BYTES + 32'd1;
`else
    localparam int unsigned FRAMES = BYTES;
`endif
    localparam int          CW          = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [2:0]  FRAMES_LAST = 3'(FRAMES - 32'd1);

    tx_state_e              state_r;
    tx_state_e              state_s;
    logic [CW-1:0]          baud_r;
    logic [2:0]             bit_r;
    logic [2:0]             frames_left_r;
    logic [7:0]             shift_r;
    logic [SAMPLE_W-1:0]    hold_r;
    logic                   tx_r;
    logic                   busy_r;
    logic                   rst_q_r;

    logic                   baud_end_s;
    logic                   pop_s;
    logic                   load_next_s;
    logic                   tx_s;
    logic                   push_s;
    logic [SAMPLE_W-1:0]    fifo_rdata_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_level_s;

    assign sample_ready = !rst_q_r && !fifo_full_s;
    assign push_s       = sample_valid && sample_ready;
    assign baud_end_s   = (baud_r == BAUD_LAST);
    assign tx           = tx_r;
    assign busy         = busy_r;
    assign fifo_level   = fifo_level_s;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (sample_in),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Byte-engine next state, pop/reload requests and the line level for this state.
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        load_next_s = 1'b0;
        tx_s        = 1'b1;
        case (state_r)
            IDLE: begin
                tx_s = 1'b1;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                tx_s = 1'b0;
                if (baud_end_s) begin
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                tx_s = shift_r[bit_r];
                if (baud_end_s && (bit_r == 3'd7)) begin
                    state_s = STOP;
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                tx_s = 1'b1;
                if (baud_end_s) begin
                    // Chain straight into the next frame so the line has no idle gap.
                    if (frames_left_r != 3'd0) begin
                        load_next_s = 1'b1;
                        state_s     = START;
                    end else if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        state_s = START;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                tx_s    = 1'b1;
                state_s = IDLE;
            end
        endcase
    end

    // State register, baud/bit counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            rst_q_r <= 1'b1;
        end else begin
            state_r <= state_s;
            rst_q_r <= 1'b0;
            // tx follows the current state one cycle later, from a flop.
            tx_r    <= tx_s;
            busy_r  <= (state_r != IDLE) || (fifo_level_s != '0);
            // Counter sits at zero in IDLE so every frame starts from a fresh bit period.
            if ((state_r == IDLE) || baud_end_s) begin
                baud_r <= '0;
            end else begin
                baud_r <= baud_r + BAUD_ONE;
            end
            if ((state_r == DATA) && baud_end_s) begin
                bit_r <= bit_r + 3'd1;
            end
        end
    end

    // Sample holding register and per-frame byte loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r       <= 8'h00;
            hold_r        <= '0;
            frames_left_r <= 3'd0;
        end else if (pop_s) begin
`ifdef SYNC_BYTE_EN
            shift_r       <= SYNC_BYTE;
            hold_r        <= fifo_rdata_s;
`else
            shift_r       <= fifo_rdata_s[SAMPLE_W-1 -: 8];
            hold_r        <= fifo_rdata_s << 4'd8;
`endif
            frames_left_r <= FRAMES_LAST;
        end else if (load_next_s) begin
            shift_r       <= hold_r[SAMPLE_W-1 -: 8];
            hold_r        <= hold_r << 4'd8;
            frames_left_r <= frames_left_r - 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_sample_tx.sv
// Self-checking bench for uart_sample_tx: a UART receiver model decodes the
// tx line into samples and compares them with a queue of accepted samples.
module tb_uart_sample_tx;

    localparam int CPB   = 4;
    localparam int SW    = 16;
    localparam int DEPTH = 8;
    localparam int BYTES = SW / 8;
`ifdef SYNC_BYTE_EN
    localparam int FRAMES = BYTES + 1;
`else
    localparam int FRAMES = BYTES;
`endif
    localparam int FRAME_CYC  = 10 * CPB;
    localparam int SAMPLE_CYC = FRAMES * FRAME_CYC;
    localparam int STOP_AT    = CPB / 2 + 9 * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          tx;
    logic          busy;
    logic [3:0]    fifo_level;

    int            checks = 0;
    int            errors = 0;
    longint        cyc = 0;
    logic [SW-1:0] exp_q[$];
    longint        start_q[$];

    logic          rx_active = 1'b0;
    int            rx_t;
    int            rx_frame = 0;
    logic [7:0]    rx_byte;
    logic [SW-1:0] rx_acc;
    logic [SW-1:0] burst_d;
    int            burst_acc;

    uart_sample_tx #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_W     (SW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .tx           (tx),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART receiver: detect start at a falling edge, sample each bit mid-period.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            rx_active = 1'b0;
            rx_frame  = 0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_t      = 0;
                start_q.push_back(cyc);
            end
        end else begin
            rx_t++;
            if (rx_t == CPB / 2) begin
                check("start_bit", tx, 1'b0);
                check("busy_in_frame", busy, 1'b1);
            end else if (rx_t > CPB / 2 && rx_t < STOP_AT && ((rx_t - CPB / 2) % CPB) == 0) begin
                rx_byte[(rx_t - CPB / 2) / CPB - 1] = tx;
            end else if (rx_t == STOP_AT) begin
                check("stop_bit", tx, 1'b1);
                rx_active = 1'b0;
`ifdef SYNC_BYTE_EN
                if (rx_frame == 0) check("sync_byte", rx_byte, 8'hA5);
                else rx_acc = {rx_acc[SW-9:0], rx_byte};
`else
                rx_acc = {rx_acc[SW-9:0], rx_byte};
`endif
                rx_frame++;
                if (rx_frame == FRAMES) begin
                    rx_frame = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_sample: got %0h expected none", rx_acc);
                    end else begin
                        check("sample_data", rx_acc, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic push(input logic [SW-1:0] d);
        int   n = 0;
        logic done = 1'b0;
        sample_valid = 1'b1;
        sample_in    = d;
        while (!done && n < 2000) begin
            @(negedge clk);
            if (sample_ready) begin
                exp_q.push_back(d);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        sample_valid = 1'b0;
        check("push_accepted", done, 1'b1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || rx_active) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drain_in_time"}, (n < 20000), 1'b1);
        check({name, "_idle_tx"}, tx, 1'b1);
        check({name, "_idle_busy"}, busy, 1'b0);
        check({name, "_idle_level"}, fifo_level, 4'd0);
    endtask

    // One sample into an idle block: latency, busy window, frame spacing.
    task automatic single(input string name, input logic [SW-1:0] d);
        start_q.delete();
        push(d);
        @(posedge clk); #1;
        check({name, "_tx_edge1"}, tx, 1'b1);
        @(posedge clk); #1;
        check({name, "_tx_edge2"}, tx, 1'b0);
        for (int k = 3; k <= SAMPLE_CYC + 1; k++) begin
            @(posedge clk); #1;
        end
        check({name, "_busy_last_stop"}, busy, 1'b1);
        @(posedge clk); #1;
        check({name, "_busy_fall"}, busy, 1'b0);
        drain(name);
        check({name, "_frames"}, start_q.size(), FRAMES);
        if (start_q.size() == FRAMES)
            check({name, "_span"}, start_q[FRAMES-1] - start_q[0], (FRAMES - 1) * FRAME_CYC);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_level", fifo_level, 4'd0);
        check("reset_ready", sample_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", sample_ready, 1'b1);

        // Single samples
        single("s1234", 16'h1234);
        single("sbeef", 16'hBEEF);
        single("srand", SW'($urandom));

        // Burst with valid held high, including a full-FIFO cycle with a pop
        start_q.delete();
        burst_d   = SW'($urandom);
        burst_acc = 0;
        sample_valid = 1'b1;
        for (int k = 0; k <= SAMPLE_CYC + 2; k++) begin
            sample_in = burst_d;
            @(negedge clk);
            if (k == SAMPLE_CYC + 1) check("full_pop_no_push", sample_ready, 1'b0);
            if (sample_ready) begin
                exp_q.push_back(burst_d);
                burst_acc++;
                burst_d = burst_d + 1'b1;
            end
            @(posedge clk); #1;
            if (k == 7) check("ready_before_full", sample_ready, 1'b1);
            if (k == 8) check("ready_falls_full", sample_ready, 1'b0);
            if (k == 11) check("burst_accepted", burst_acc, 9);
            if (k == SAMPLE_CYC) check("ready_low_before_pop", sample_ready, 1'b0);
            if (k == SAMPLE_CYC + 1) begin
                check("ready_rises_after_pop", sample_ready, 1'b1);
                check("level_after_pop", fifo_level, 4'd7);
            end
            if (k == SAMPLE_CYC + 2) begin
                check("level_refill", fifo_level, 4'd8);
                check("total_accepted", burst_acc, 10);
            end
        end
        sample_valid = 1'b0;
        drain("burst");
        check("burst_frames", start_q.size(), 10 * FRAMES);
        if (start_q.size() == 10 * FRAMES)
            check("burst_continuous", start_q[10*FRAMES-1] - start_q[0], (10 * FRAMES - 1) * FRAME_CYC);

        // Reset during the second byte of a sample
        push(16'h1234);
        push(16'h5678);
        push(16'h9ABC);
        repeat (55) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_level", fifo_level, 4'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", sample_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        single("s00ff", 16'h00FF);

        // Random samples with random gaps
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 90)) begin
                    @(posedge clk); #1;
                end
            end
            push(SW'($urandom));
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
